// File: rtl/dmem_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int unsigned DMEM_DATA_W = 16;
    localparam int unsigned DMEM_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array, registered read, no reset on storage.
// Ports: clk, we (write enable), idx (word index), wdata (write data),
//        rdata (registered read data, read-before-write).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned IDX_W = 10
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IDX_W-1:0]       idx,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] rdata
);

    logic [DMEM_DATA_W-1:0] mem [2**IDX_W];

    // Storage write and registered read of the same index.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage data port.
// Accepts one request in IDLE, stalls the pipeline for LATENCY cycles,
// then pulses ready. Reads return mem[word index] on data_out, writes
// commit on the edge leaving DONE.
// Ports: clk, rst (async, active-high), enable/wr/addr/data_in (request),
//        data_out (read data, held until next read), stall, ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned WORD_ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   wr,
    input  logic [DMEM_ADDR_W-1:0] addr,
    input  logic [DMEM_DATA_W-1:0] data_in,
    output logic [DMEM_DATA_W-1:0] data_out,
    output logic                   stall,
    output logic                   ready
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t            state_q;
    dmem_state_t            state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   wr_q;
    logic [WORD_ADDR_W-1:0] idx_q;
    logic [DMEM_DATA_W-1:0] wdata_q;
    logic [DMEM_DATA_W-1:0] hold_q;
    logic [DMEM_DATA_W-1:0] rdata;
    logic [WORD_ADDR_W-1:0] arr_idx;
    logic                   arr_we;

    // Byte-select bit and address bits above the word index are discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[DMEM_ADDR_W-1:WORD_ADDR_W+1], addr[0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and array control.
    // In IDLE the array looks at the live address so that a LATENCY==1 read
    // has its data captured on the accepting edge.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        ready   = 1'b0;
        arr_we  = 1'b0;
        arr_idx = idx_q;
        case (state_q)
            IDLE: begin
                stall   = enable;
                arr_idx = addr[WORD_ADDR_W:1];
                if (enable) begin
                    state_d = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                arr_we  = wr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // Request latches, latency counter and read-data holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        wr_q    <= wr;
                        idx_q   <= addr[WORD_ADDR_W:1];
                        wdata_q <= data_in;
                    end
                end
                BUSY: cnt_q <= cnt_q - CNT_W'(1);
                DONE: begin
                    if (!wr_q) begin
                        hold_q <= rdata;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // During a read's DONE cycle the freshly captured array word is shown;
    // otherwise the last completed read is held.
    assign data_out = (state_q == DONE && !wr_q) ? rdata : hold_q;

    dmem_array #(
        .IDX_W (WORD_ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (wdata_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en4;
    logic        en1;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] dout4;
    logic [15:0] dout1;
    logic        stall4;
    logic        stall1;
    logic        ready4;
    logic        ready1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [15:0] sb[$];
    logic [15:0] last_dout [2];

    typedef struct {
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(4), .WORD_ADDR_W(10)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(dout4), .stall(stall4), .ready(ready4)
    );

    dmem_responder #(.LATENCY(1), .WORD_ADDR_W(10)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(dout1), .stall(stall1), .ready(ready1)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // One request on the selected responder; called at posedge+1 of the
    // accepting cycle and returns at posedge+1 of the cycle after ready.
    task automatic req(input bit sel, input bit w, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp,
                       input bit noise, input int lat);
        logic st, rd;
        logic [15:0] dq;
        if (sel) en1 = 1'b1; else en4 = 1'b1;
        wr = w; addr = a; data_in = d;
        if (!w) sb.push_back(exp);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            st = sel ? stall1 : stall4;
            rd = sel ? ready1 : ready4;
            dq = sel ? dout1 : dout4;
            if (c < lat) begin
                chk("stall_pending", 16'(st), 16'd1);
                chk("ready_pending", 16'(rd), 16'd0);
                chk("dout_hold", dq, last_dout[sel]);
            end else begin
                chk("stall_done", 16'(st), 16'd0);
                chk("ready_done", 16'(rd), 16'd1);
                if (!w) begin
                    logic [15:0] e;
                    if (sb.size() == 0) begin
                        chk("sb_empty", 16'd1, 16'd0);
                        e = 16'hxxxx;
                    end else begin
                        e = sb.pop_front();
                    end
                    chk("read_data", dq, e);
                    last_dout[sel] = e;
                end else begin
                    chk("write_dout", dq, last_dout[sel]);
                end
            end
            @(posedge clk); #1;
            if (c == 0) begin
                en4 = 1'b0; en1 = 1'b0;
                if (noise) begin
                    en4 = 1'b1; wr = ~w; addr = 16'h0030; data_in = 16'h2222;
                end
            end
            if (c == lat - 1) begin
                en4 = 1'b0; en1 = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        tbl[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        tbl[2] = '{1'b0, 16'h0011, 16'h0000, 16'hBEEF};
        tbl[3] = '{1'b0, 16'h0810, 16'h0000, 16'hBEEF};
        tbl[4] = '{1'b1, 16'h0030, 16'h5A5A, 16'h0000};
        tbl[5] = '{1'b0, 16'hF831, 16'h0000, 16'h5A5A};
        tbl[6] = '{1'b1, 16'h07FE, 16'h7E57, 16'h0000};
        tbl[7] = '{1'b0, 16'hFFFF, 16'h0000, 16'h7E57};
        last_dout[0] = 16'h0000;
        last_dout[1] = 16'h0000;

        // Reset: stall forced low even with enable high.
        rst = 1'b1; en4 = 1'b1; en1 = 1'b1; wr = 1'b1; addr = 16'h0010; data_in = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        chk("rst_stall4", 16'(stall4), 16'd0);
        chk("rst_stall1", 16'(stall1), 16'd0);
        chk("rst_ready4", 16'(ready4), 16'd0);
        chk("rst_dout4", dout4, 16'h0000);
        chk("rst_dout1", dout1, 16'h0000);
        en4 = 1'b0; en1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven back-to-back requests.
        for (int i = 0; i < 8; i++) begin
            req(1'b0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp, 1'b0, 4);
        end

        // wr without enable is ignored.
        wr = 1'b1; addr = 16'h0010; data_in = 16'hDEAD;
        @(negedge clk);
        chk("idle_wr_stall", 16'(stall4), 16'd0);
        chk("idle_wr_ready", 16'(ready4), 16'd0);
        @(posedge clk); #1;
        req(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 4);

        // Input changes during BUSY are ignored.
        req(1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b1, 4);
        req(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 4);
        req(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h5A5A, 1'b0, 4);

        // Reset in the middle of a write discards it.
        req(1'b0, 1'b1, 16'h0040, 16'hAAAA, 16'h0000, 1'b0, 4);
        req(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hAAAA, 1'b0, 4);
        en4 = 1'b1; wr = 1'b1; addr = 16'h0040; data_in = 16'h1234;
        @(negedge clk);
        chk("rstw_stall_c0", 16'(stall4), 16'd1);
        @(posedge clk); #1;
        en4 = 1'b0;
        @(negedge clk);
        chk("rstw_stall_c1", 16'(stall4), 16'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstw_stall", 16'(stall4), 16'd0);
        chk("rstw_ready", 16'(ready4), 16'd0);
        chk("rstw_dout", dout4, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        last_dout[0] = 16'h0000;
        last_dout[1] = 16'h0000;
        repeat (6) @(posedge clk);
        #1;
        chk("rstw_idle_ready", 16'(ready4), 16'd0);
        req(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hAAAA, 1'b0, 4);

        // LATENCY=1 responder.
        req(1'b1, 1'b1, 16'h0100, 16'hC0DE, 16'h0000, 1'b0, 1);
        req(1'b1, 1'b0, 16'h0100, 16'h0000, 16'hC0DE, 1'b0, 1);
        req(1'b1, 1'b1, 16'h0102, 16'h0F0F, 16'h0000, 1'b0, 1);
        req(1'b1, 1'b0, 16'h0901, 16'h0000, 16'hC0DE, 1'b0, 1);
        req(1'b1, 1'b0, 16'h0103, 16'h0000, 16'h0F0F, 1'b0, 1);

        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that serves the pipeline's MEM-stage data port (enable / wr / addr / data_in → data_out). It replaces the single-cycle data memory with a slave that has configurable access latency. While an access is outstanding it returns a stall to the pipeline, and it pulses `ready` when the access completes. Storage is word-organised and word-addressed from 16-bit byte addresses.

## Interface
- `LATENCY`, 4: cycles from request acceptance to completion; legal range ≥1.
- `WORD_ADDR_W`, 10: word-index width; depth is 2**WORD_ADDR_W 16-bit words.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: request valid; sampled only in IDLE.
- `wr` in 1: 1 = write, 0 = read; meaningful only with `enable`.
- `addr` in 16: byte address; bit 0 ignored; word index = `addr[WORD_ADDR_W:1]`.
- `data_in` in 16: write data.
- `data_out` out 16: registered read data; holds its value until the next read completes.
- `stall` out 1: pipeline hold; high while a request is pending.
- `ready` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - `stall` = `enable` (combinational).
  - On an edge with `enable`=1: latch `wr`, the word index and `data_in`; load `cnt` = LATENCY-1.
  - Next state is DONE if LATENCY==1, otherwise BUSY.
- **BUSY**
  - `stall`=1, `ready`=0.
  - Decrement `cnt` each cycle.
  - When `cnt`==1 at the edge, go to DONE.
  - Changes on `enable`, `wr`, `addr` or `data_in` are ignored; only latched values are used.
- **DONE**
  - `stall`=0, `ready`=1.
  - Read: `data_out` already holds `mem[latched idx]`, captured on the edge entering DONE.
  - Write: `mem[latched idx]` ← latched data on the edge leaving DONE. `data_out` is unchanged.
  - Always returns to IDLE. A new request can be presented in the following cycle.
- Addresses wrap: address bits above `WORD_ADDR_W` are discarded, so aliases map to the same word.
- `wr`=1 with `enable`=0 is ignored.
- Reset behaviour:
  - State → IDLE, `cnt` → 0, `data_out` → 0x0000, `ready` → 0.
  - `stall` is forced to 0 while `rst` is high.
  - Storage contents are not cleared.
  - A write pending at reset is discarded and never committed.

## Timing
- Request accepted in cycle t.
- `stall`=1 in cycles t … t+LATENCY-1.
- `ready`=1 and `stall`=0 in cycle t+LATENCY.
- Read data is valid on `data_out` in cycle t+LATENCY and afterwards.
- Read-after-write: a read accepted in cycle t+LATENCY+1 or later returns the written value.
- Minimum request spacing is LATENCY+1 cycles; throughput is one access per LATENCY+1 cycles.
- Reset values: `data_out`=0x0000, `ready`=0, `stall`=0.

## Structure
- Shared package `dmem_pkg`:
  - State enum `dmem_state_t` {IDLE, BUSY, DONE}.
  - Constants `DMEM_DATA_W`=16 and `DMEM_ADDR_W`=16.
- One sub-module, `dmem_array`:
  - Single-port synchronous 16-bit array.
  - Ports: clk, we, idx, wdata, rdata.
  - Registered read, no reset on storage.
- FSM, counter and request latches live in `dmem_responder`.

## Test plan
All scenarios use LATENCY=4 and WORD_ADDR_W=10 unless stated.

1. Reset, then write 0xBEEF to 0x0010 with `enable`=`wr`=1 at cycle 0 → `stall` high in cycles 0–3; `ready` pulses in cycle 4 with `stall`=0; `data_out` stays 0x0000.
2. Read 0x0010 → `ready` in cycle 4 with `data_out`=0xBEEF. Read 0x0011 → 0xBEEF (bit 0 ignored). Read 0x0810 → 0xBEEF (wrap).
3. Start a write of 0x1111 to 0x0020, then drive `addr`=0x0030 and `data_in`=0x2222 during BUSY → reading 0x0020 returns 0x1111 and reading 0x0030 returns the old value.
4. Back-to-back: issue a read in the cycle right after a `ready` pulse → it is accepted immediately, with `stall` high for exactly 4 cycles.
5. Write 0x1234 to 0x0040 and assert `rst` in cycle 2 → `stall` and `ready` drop to 0 and `data_out`=0x0000 immediately; a later read of 0x0040 returns the pre-reset contents, not 0x1234.
6. LATENCY=1: read request at cycle 0 → `stall`=1 in cycle 0 only; `ready`=1 with valid data in cycle 1.
